// File: rtl/day10_stream_encoder.sv
// Parses day-10 ASCII lines into header/row words for the GF(2) solver.
// Each valid line yields {rows,cols} then one word per light; EOF appends a zero terminator.
module day10_stream_encoder #(
   parameter int MAX_ROWS = 32,
   parameter int MAX_COLS = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        err,
   output logic        done
);
   localparam int RW = $clog2(MAX_ROWS + 2);
   localparam int CW = $clog2(MAX_COLS + 2);
   localparam int IW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

   typedef enum logic [3:0] {
      S_LINE, S_LIGHTS, S_BTNS, S_NUM, S_SKIP, S_HDR, S_ROWS, S_TERM, S_DONE
   } state_t;

   state_t state, state_nxt, fail_state;

   logic [MAX_COLS-1:0] mat [MAX_ROWS];
   logic [MAX_ROWS-1:0] tgt;
   logic [RW-1:0]       rows, rows_nxt;
   logic [CW-1:0]       btn, btn_nxt;
   logic [7:0]          num, num_nxt, num_sat;
   logic [11:0]         num_calc;
   logic [IW-1:0]       r, r_nxt;
   logic                err_line, err_line_nxt, eof, eof_nxt;
   logic                take, xfer, start_line, set_light, commit, set_err;
   logic                is_digit, is_space, is_nl;
   logic [MAX_COLS-1:0] row_bits;
   logic                row_tgt;
   logic [31:0]         word_nxt;

   assign take     = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;
   assign is_digit = (in_data >= "0") && (in_data <= "9");
   assign is_space = (in_data == " ") || (in_data == 8'h0d);
   assign is_nl    = (in_data == 8'h0a);
   assign num_calc = 12'(num) * 12'd10 + 12'(in_data - 8'h30);
   assign num_sat  = (num_calc > 12'd255) ? 8'hff : num_calc[7:0];
   // A bad '\n' already ends the line, so there is nothing left to skip.
   assign fail_state = is_nl ? S_LINE : S_SKIP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_LINE;
         rows      <= '0;
         btn       <= '0;
         num       <= '0;
         r         <= '0;
         err_line  <= 1'b0;
         eof       <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         rows      <= rows_nxt;
         btn       <= btn_nxt;
         num       <= num_nxt;
         r         <= r_nxt;
         err_line  <= err_line_nxt;
         eof       <= eof_nxt;
         if (set_err) err <= 1'b1;
         out_valid <= (state_nxt == S_HDR) || (state_nxt == S_ROWS) || (state_nxt == S_TERM);
         out_data  <= word_nxt;
         out_last  <= (state_nxt == S_TERM);
      end
   end

   always_comb begin
      state_nxt    = state;
      rows_nxt     = rows;
      btn_nxt      = btn;
      num_nxt      = num;
      r_nxt        = r;
      err_line_nxt = err_line;
      eof_nxt      = eof;
      start_line   = 1'b0;
      set_light    = 1'b0;
      commit       = 1'b0;
      set_err      = 1'b0;
      case (state)
         S_LINE: if (take && !is_space && !is_nl) begin
            if (in_data == "[") begin
               start_line   = 1'b1;
               rows_nxt     = '0;
               btn_nxt      = '0;
               err_line_nxt = 1'b0;
               state_nxt    = S_LIGHTS;
            end else begin
               set_err   = 1'b1;
               state_nxt = S_SKIP;
            end
         end
         S_LIGHTS: if (take) begin
            if (((in_data == ".") || (in_data == "#")) && (rows != RW'(MAX_ROWS))) begin
               set_light = 1'b1;
               rows_nxt  = rows + RW'(1);
            end else if ((in_data == "]") && (rows != '0)) begin
               state_nxt = S_BTNS;
            end else begin
               set_err   = 1'b1;
               state_nxt = fail_state;
            end
         end
         S_BTNS: if (take && !is_space) begin
            if ((in_data == "(") && (btn != CW'(MAX_COLS))) begin
               num_nxt   = '0;
               state_nxt = S_NUM;
            end else if (in_data == "{") begin
               state_nxt = S_SKIP;
            end else if (is_nl) begin
               state_nxt = S_HDR;
            end else begin
               set_err   = 1'b1;
               state_nxt = fail_state;
            end
         end
         S_NUM: if (take) begin
            if (is_digit) begin
               num_nxt = num_sat;
            end else if (((in_data == ",") || (in_data == ")")) && (16'(num) < 16'(rows))) begin
               commit  = 1'b1;
               num_nxt = '0;
               if (in_data == ")") begin
                  btn_nxt   = btn + CW'(1);
                  state_nxt = S_BTNS;
               end
            end else begin
               set_err   = 1'b1;
               state_nxt = fail_state;
            end
         end
         S_SKIP: if (take && is_nl) state_nxt = err_line ? S_LINE : S_HDR;
         S_HDR: if (xfer) begin
            r_nxt     = '0;
            state_nxt = S_ROWS;
         end
         S_ROWS: if (xfer) begin
            if (RW'(r) == rows - RW'(1)) state_nxt = eof ? S_TERM : S_LINE;
            else r_nxt = r + IW'(1);
         end
         S_TERM: if (xfer) state_nxt = S_DONE;
         default: ;
      endcase
      if (set_err) err_line_nxt = 1'b1;
      // The final byte behaves as if a '\n' followed it.
      if (take && in_last) begin
         eof_nxt = 1'b1;
         case (state_nxt)
            S_LINE:          state_nxt = S_TERM;
            S_LIGHTS, S_NUM: begin
               set_err      = 1'b1;
               err_line_nxt = 1'b1;
               state_nxt    = S_TERM;
            end
            S_BTNS:          state_nxt = S_HDR;
            S_SKIP:          state_nxt = err_line_nxt ? S_TERM : S_HDR;
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready = (state == S_LINE) || (state == S_LIGHTS) || (state == S_BTNS) ||
                 (state == S_NUM) || (state == S_SKIP);
      done     = (state == S_DONE);
   end

   // Output words are built from next-state values so they can be registered.
   always_comb begin
      row_bits = '0;
      row_tgt  = 1'b0;
      for (int i = 0; i < MAX_ROWS; i++) begin
         if (IW'(i) == r_nxt) begin
            row_bits = mat[i];
            row_tgt  = tgt[i];
         end
      end
      case (state_nxt)
         S_HDR:   word_nxt = {16'(rows_nxt), 16'(btn_nxt)};
         S_ROWS:  word_nxt = 32'(row_bits) | (32'(row_tgt) << btn_nxt);
         default: word_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || start_line) begin
         tgt <= '0;
         for (int i = 0; i < MAX_ROWS; i++) mat[i] <= '0;
      end else begin
         for (int i = 0; i < MAX_ROWS; i++) begin
            if (set_light && (RW'(i) == rows)) tgt[i] <= (in_data == "#");
            for (int j = 0; j < MAX_COLS; j++) begin
               if (commit && (16'(i) == 16'(num)) && (CW'(j) == btn)) mat[i][j] <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_day10_stream_encoder.sv
// Directed, table-driven bench for day10_stream_encoder.
// Each vector is a complete input file with its expected word stream and error flag.
module tb_day10_stream_encoder;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_last;
   logic [7:0]  in_data;
   logic        out_valid, out_ready, out_last, err, done;
   logic [31:0] out_data;

   always #5 clk = ~clk;

   day10_stream_encoder #(.MAX_ROWS(32), .MAX_COLS(31)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .err(err), .done(done)
   );

   typedef struct {
      string text;
      bit    bp;
      bit    exp_err;
      int    first;
      int    count;
   } vec_t;

   vec_t        vecs [8];
   int          nvec = 0;
   logic [31:0] exp_q [$];
   logic [31:0] got_w [32];
   logic        got_l [32];
   int          got_n, nl_cyc, hdr_cyc, stall_bad, emit_bad;
   int          checks = 0;
   int          errors = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addVec(input string t, input bit bp, input bit e);
      vecs[nvec].text    = t;
      vecs[nvec].bp      = bp;
      vecs[nvec].exp_err = e;
      vecs[nvec].first   = exp_q.size();
      vecs[nvec].count   = 0;
      nvec++;
   endtask

   task automatic addWord(input logic [31:0] w);
      exp_q.push_back(w);
      vecs[nvec-1].count++;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Feeds text byte by byte and records every output transfer; stop_at > 0 returns
   // just before that word index would transfer.
   task automatic applyStimulus(input string text, input bit bp, input int stop_at);
      int          idx;
      logic        pv, pr, pl;
      logic [31:0] pd;
      idx = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      got_n = 0; nl_cyc = -1; hdr_cyc = -1; stall_bad = 0; emit_bad = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (idx < text.len()) begin
            in_valid = 1'b1;
            in_data  = text[idx];
            in_last  = (idx == text.len() - 1);
         end else begin
            in_valid = 1'b0;
            in_data  = 8'h00;
            in_last  = 1'b0;
         end
         #1;
         if (done) break;
         if (stop_at > 0 && out_valid && got_n == stop_at) return;
         if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) stall_bad++;
         if (out_valid && in_ready) emit_bad++;
         if (out_valid && hdr_cyc < 0) hdr_cyc = cyc;
         if (out_valid && out_ready) begin
            if (got_n < 32) begin
               got_w[got_n] = out_data;
               got_l[got_n] = out_last;
            end
            got_n++;
         end
         if (in_valid && in_ready) begin
            if (in_data == 8'h0a && nl_cyc < 0) nl_cyc = cyc;
            idx++;
         end
         pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic compareRun(input string tag, input int first, input int count,
                             input bit exp_err, input bit chk_lat);
      logic [32:0] g;
      checkOutput({tag, ".count"}, 64'(got_n), 64'(count));
      for (int i = 0; i < count; i++) begin
         g = (i < got_n && i < 32) ? {got_l[i], got_w[i]} : {1'b1, 32'hdeadbeef};
         checkOutput($sformatf("%s.word%0d", tag, i), 64'(g), 64'({i == count - 1, exp_q[first + i]}));
      end
      checkOutput({tag, ".err"}, 64'(err), 64'(exp_err));
      checkOutput({tag, ".done"}, 64'(done), 64'd1);
      checkOutput({tag, ".stall_hold"}, 64'(stall_bad), 64'd0);
      checkOutput({tag, ".in_ready_emit"}, 64'(emit_bad), 64'd0);
      if (chk_lat) checkOutput({tag, ".hdr_latency"}, 64'(hdr_cyc), 64'(nl_cyc + 1));
   endtask

   initial begin
      string ex, md;
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;

      ex = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n";
      md = "[";
      for (int i = 0; i < 11; i++) md = {md, "."};
      md = {md, "#] (10) (0,11)\n"};

      addVec(ex, 1'b0, 1'b0);
      addWord(32'h00040006); addWord(32'h30); addWord(32'h62); addWord(32'h5C);
      addWord(32'h0B); addWord(32'h0);
      addVec(ex, 1'b1, 1'b0);
      addWord(32'h00040006); addWord(32'h30); addWord(32'h62); addWord(32'h5C);
      addWord(32'h0B); addWord(32'h0);
      addVec("[..] (2)\n[#] (0)\n", 1'b0, 1'b1);
      addWord(32'h00010001); addWord(32'h3); addWord(32'h0);
      addVec("[#.] (0,1)", 1'b0, 1'b0);
      addWord(32'h00020001); addWord(32'h3); addWord(32'h1); addWord(32'h0);
      addVec("\015\n\n[#] (0)\015\n", 1'b0, 1'b0);
      addWord(32'h00010001); addWord(32'h3); addWord(32'h0);
      addVec("[]\n[#] (0)\n", 1'b0, 1'b1);
      addWord(32'h00010001); addWord(32'h3); addWord(32'h0);
      addVec(md, 1'b0, 1'b0);
      addWord(32'h000C0002); addWord(32'h2);
      for (int i = 1; i < 10; i++) addWord(32'h0);
      addWord(32'h1); addWord(32'h6); addWord(32'h0);

      resetDut();
      #1;
      checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset.out_data", 64'(out_data), 64'd0);
      checkOutput("reset.out_last", 64'(out_last), 64'd0);
      checkOutput("reset.err", 64'(err), 64'd0);
      checkOutput("reset.done", 64'(done), 64'd0);

      for (int v = 0; v < nvec; v++) begin
         resetDut();
         applyStimulus(vecs[v].text, vecs[v].bp, 0);
         compareRun($sformatf("vec%0d", v), vecs[v].first, vecs[v].count, vecs[v].exp_err, v == 0);
      end

      // Reset while the second row word is being presented.
      resetDut();
      applyStimulus(ex, 1'b0, 2);
      checkOutput("midrst.reach", 64'(got_n), 64'd2);
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst.out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst.out_data", 64'(out_data), 64'd0);
      checkOutput("midrst.out_last", 64'(out_last), 64'd0);
      checkOutput("midrst.in_ready", 64'(in_ready), 64'd1);
      checkOutput("midrst.err", 64'(err), 64'd0);
      checkOutput("midrst.done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(ex, 1'b0, 0);
      compareRun("midrst.rerun", vecs[0].first, vecs[0].count, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
